// File: rtl/time_pkg.sv
// Shared types and helpers for the BCD time-field counters.
// Supplies the BCD digit type, digit validation and the int->BCD
// encoder used to build the MAX/MIN comparison constants.
package time_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX_DIGIT = 4'd9;

   // Widest field supported; int_to_bcd always returns this many digits.
   localparam int MAX_DIGITS = 4;

   // A nibble is a legal BCD digit when it is 0..9.
   function automatic logic is_bcd(input bcd_t d);
      return (d <= BCD_MAX_DIGIT);
   endfunction

   // Encode a binary integer into packed BCD, digit 0 in the LSBs.
   // Digits at or above 'digits' are left zero.
   function automatic logic [4*MAX_DIGITS-1:0] int_to_bcd(input int value, input int digits);
      logic [4*MAX_DIGITS-1:0] r;
      int                      v;
      r = '0;
      v = value;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i < digits) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of a time-field counter.
// Steps up or down by one with 9<->0 roll-over, or loads a value.
// digit_max / digit_zero feed the ripple enables of the next digit.
module bcd_digit_cell
   import time_pkg::*;
#(
   parameter bcd_t RESET_VAL = 4'd0
) (
   input  logic clk,
   input  logic reset,
   input  logic up_en,
   input  logic down_en,
   input  logic load,
   input  bcd_t load_val,
   output bcd_t digit,
   output logic digit_max,
   output logic digit_zero
);

   bcd_t digit_reg;
   bcd_t digit_next;

   assign digit      = digit_reg;
   assign digit_max  = (digit_reg == BCD_MAX_DIGIT);
   assign digit_zero = (digit_reg == 4'd0);

   // Next digit value: load wins over stepping; steps roll 9->0 and 0->9.
   always_comb begin
      digit_next = digit_reg;
      if (load) begin
         digit_next = load_val;
      end else if (up_en) begin
         digit_next = digit_max ? 4'd0 : digit_reg + 4'd1;
      end else if (down_en) begin
         digit_next = digit_zero ? BCD_MAX_DIGIT : digit_reg - 4'd1;
      end
   end

   // Digit register with synchronous reset to this digit of MIN_VAL.
   always_ff @(posedge clk) begin
      if (reset) begin
         digit_reg <= RESET_VAL;
      end else begin
         digit_reg <= digit_next;
      end
   end

endmodule

// File: rtl/time_field_counter.sv
// Multi-digit BCD field counter (seconds/minutes/hours) with up/down
// stepping, validated parallel set and same-cycle carry/borrow for chaining.
// Build option: define TFC_SATURATE_EN to hold at the limits instead of
// wrapping; carry_out/borrow_out are then tied low.
module time_field_counter
   import time_pkg::*;
#(
   parameter int DIGITS  = 2,
   parameter int MAX_VAL = 59,
   parameter int MIN_VAL = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inc,
   input  logic                dec,
   input  logic                set,
   input  logic [4*DIGITS-1:0] set_val,
   output logic [4*DIGITS-1:0] q,
   output logic                at_max,
   output logic                at_min,
   output logic                carry_out,
   output logic                borrow_out,
   output logic                set_err
);

   localparam int W = 4 * DIGITS;

   localparam logic [4*MAX_DIGITS-1:0] MAX_BCD_FULL = int_to_bcd(MAX_VAL, DIGITS);
   localparam logic [4*MAX_DIGITS-1:0] MIN_BCD_FULL = int_to_bcd(MIN_VAL, DIGITS);
   localparam logic [W-1:0]            MAX_BCD      = MAX_BCD_FULL[W-1:0];
   localparam logic [W-1:0]            MIN_BCD      = MIN_BCD_FULL[W-1:0];

   logic              set_valid;
   logic              set_accept;
   logic              step_up;
   logic              step_down;
   logic              wrap_up;
   logic              wrap_down;
   logic              load;
   logic [W-1:0]      load_val;
   logic [DIGITS:0]   up_chain;
   logic [DIGITS:0]   down_chain;
   logic [DIGITS-1:0] digit_max;
   logic [DIGITS-1:0] digit_zero;
   logic              set_err_reg;
   logic              unused_chain_top;

   assign at_max = (q == MAX_BCD);
   assign at_min = (q == MIN_BCD);

   // Set value is legal when every nibble is BCD and it lies in [MIN, MAX].
   // With all nibbles valid, an unsigned compare of packed BCD orders correctly.
   always_comb begin
      set_valid = (set_val >= MIN_BCD) && (set_val <= MAX_BCD);
      for (int i = 0; i < DIGITS; i++) begin
         if (!is_bcd(set_val[4*i +: 4])) begin
            set_valid = 1'b0;
         end
      end
   end

   // A step request exists only outside reset, without set, and with inc XOR dec.
   assign set_accept = set & set_valid;
   assign step_up    = ~reset & ~set & inc & ~dec;
   assign step_down  = ~reset & ~set & dec & ~inc;

`ifdef TFC_SATURATE_EN
   assign wrap_up    = 1'b0;
   assign wrap_down  = 1'b0;
   assign carry_out  = 1'b0;
   assign borrow_out = 1'b0;
`else
   assign wrap_up    = step_up & at_max;
   assign wrap_down  = step_down & at_min;
   assign carry_out  = wrap_up;
   assign borrow_out = wrap_down;
`endif

   // Inside the range the digits ripple; at a limit the field either wraps
   // via a load or (saturating build) the step is simply dropped.
   assign up_chain[0]   = step_up & ~at_max;
   assign down_chain[0] = step_down & ~at_min;

   // Field-level load: accepted set, or wrap to the opposite limit.
   assign load     = set_accept | wrap_up | wrap_down;
   assign load_val = set_accept ? set_val : (wrap_up ? MIN_BCD : MAX_BCD);

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         bcd_digit_cell #(
            .RESET_VAL (MIN_BCD[4*gi +: 4])
         ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .up_en      (up_chain[gi]),
            .down_en    (down_chain[gi]),
            .load       (load),
            .load_val   (load_val[4*gi +: 4]),
            .digit      (q[4*gi +: 4]),
            .digit_max  (digit_max[gi]),
            .digit_zero (digit_zero[gi])
         );

         assign up_chain[gi+1]   = up_chain[gi] & digit_max[gi];
         assign down_chain[gi+1] = down_chain[gi] & digit_zero[gi];
      end
   endgenerate

   // The top of each ripple chain has no further digit to feed.
   assign unused_chain_top = up_chain[DIGITS] | down_chain[DIGITS];

   // One-cycle rejection flag for the most recent set request.
   always_ff @(posedge clk) begin
      if (reset) begin
         set_err_reg <= 1'b0;
      end else begin
         set_err_reg <= set & ~set_valid;
      end
   end

   assign set_err = set_err_reg;

endmodule
